// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell stepped LSB first, one bit per clock,
// with a start/busy/done handshake and registered sum/cout/ovf.

module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// Handshake: start is sampled only while idle (busy=0); the edge that sees start=1 accepts
// a/b/cin. busy stays high until done has pulsed for one cycle; start while busy is dropped.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_co;
  logic             last_bit;

  serial_adder_fa u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state == RUN) || (state == DONE);
  assign done      = (state == DONE);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= {fa_s, res_sh[WIDTH-1:1]};
          carry  <= fa_co;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            // carry still holds the carry into the MSB, so ovf is carry-in XOR carry-out there
            sum  <= {fa_s, res_sh[WIDTH-1:1]};
            cout <= fa_co;
            ovf  <= carry ^ fa_co;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed WIDTH=8 vectors plus an exhaustive WIDTH=3 stream,
// checked by per-instance expected queues popped on every done pulse.

module tb_serial_adder;

  localparam int W8 = 8;
  localparam int W3 = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start8, cin8, busy8, done8, cout8, ovf8;
  logic [W8-1:0] a8, b8, sum8;
  logic [1:0]    st8;
  logic          start3, cin3, busy3, done3, cout3, ovf3;
  logic [W3-1:0] a3, b3, sum3;
  logic [1:0]    st3;

  serial_adder #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8), .state_dbg(st8)
  );

  serial_adder #(.WIDTH(W3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .cin(cin3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3), .ovf(ovf3), .state_dbg(st3)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last3   = -1;

  logic [W8+1:0] exp8_q[$];
  logic [W3+1:0] exp3_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // scoreboard monitors
  always @(negedge clk) begin
    if (!rst && done8) begin
      if (exp8_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL res8: unexpected done, got sum 0x%0h expected no result", sum8);
      end else begin
        check("res8 {ovf,cout,sum}", 32'({ovf8, cout8, sum8}), 32'(exp8_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done3) begin
      if (exp3_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL res3: unexpected done, got sum 0x%0h expected no result", sum3);
      end else begin
        check("res3 {ovf,cout,sum}", 32'({ovf3, cout3, sum3}), 32'(exp3_q.pop_front()));
      end
      if (last3 >= 0) check("done3 spacing", 32'(cyc - last3), 32'd5);
      last3 = cyc;
    end
  end

  // driver tasks
  task automatic wait_idle8();
    int k = 0;
    while (busy8 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) check("wait_idle8 timeout", 32'(busy8), 32'd0);
  endtask

  task automatic issue8(input logic [W8-1:0] av, input logic [W8-1:0] bv, input logic cv,
                        input logic push, input logic [W8+1:0] exp);
    @(negedge clk);
    wait_idle8();
    a8 = av;
    b8 = bv;
    cin8 = cv;
    start8 = 1'b1;
    if (push) exp8_q.push_back(exp);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic drain8();
    int k = 0;
    while (exp8_q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("drain8 queue empty", 32'(exp8_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    int done_k;
    int k;
    logic [W3-1:0] av, bv;
    logic          cv;
    logic [W3:0]   full;
    logic          ov;

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy8", 32'(busy8), 32'd0);
    check("reset done8", 32'(done8), 32'd0);
    check("reset out8", 32'({ovf8, cout8, sum8}), 32'd0);
    check("reset state8", 32'(st8), 32'd0);
    check("reset out3", 32'({busy3, done3, ovf3, cout3, sum3}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 0x0F + 0x01: latency and busy length
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    exp8_q.push_back({1'b0, 1'b0, 8'h10});
    busy_cnt = 0;
    done_k = -1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 start8 = 1'b0;
      @(negedge clk);
      if (busy8) busy_cnt++;
      if (done8 && done_k < 0) done_k = i;
    end
    check("busy cycles", 32'(busy_cnt), 32'd9);
    check("done edge", 32'(done_k), 32'd8);

    issue8(8'hFF, 8'h01, 1'b0, 1'b1, {1'b0, 1'b1, 8'h00});
    issue8(8'h7F, 8'h01, 1'b0, 1'b1, {1'b1, 1'b0, 8'h80});
    issue8(8'h80, 8'h80, 1'b0, 1'b1, {1'b1, 1'b1, 8'h00});
    issue8(8'hFF, 8'h00, 1'b1, 1'b1, {1'b0, 1'b1, 8'h00});

    // operand changes and a second start during RUN are ignored
    issue8(8'h12, 8'h34, 1'b0, 1'b1, {1'b0, 1'b0, 8'h46});
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    drain8();
    repeat (12) @(negedge clk);
    check("hold sum after 0x46", 32'(sum8), 32'h46);

    // asynchronous reset in the 4th RUN cycle of 0xAA+0x55
    issue8(8'hAA, 8'h55, 1'b0, 1'b0, '0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async rst out8", 32'({ovf8, cout8, sum8}), 32'd0);
    check("async rst busy/done", 32'({busy8, done8}), 32'd0);
    check("async rst state8", 32'(st8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("no done after rst", 32'(busy8), 32'd0);

    issue8(8'h01, 8'h02, 1'b0, 1'b1, {1'b0, 1'b0, 8'h03});
    drain8();
    repeat (5) @(negedge clk);
    check("hold sum 0x03", 32'({ovf8, cout8, sum8}), 32'h003);

    // exhaustive WIDTH=3 stream with start held high
    for (int i = 0; i < 128; i++) begin
      k = 0;
      @(negedge clk);
      while (busy3 && k < 20) begin
        @(negedge clk);
        k++;
      end
      if (k >= 20) check("wait_idle3 timeout", 32'(busy3), 32'd0);
      av = i[2:0];
      bv = i[5:3];
      cv = i[6];
      full = {1'b0, av} + {1'b0, bv} + {3'b000, cv};
      ov = (av[2] == bv[2]) && (full[2] != av[2]);
      a3 = av;
      b3 = bv;
      cin3 = cv;
      start3 = 1'b1;
      exp3_q.push_back({ov, full});
    end
    @(negedge clk);
    start3 = 1'b0;
    k = 0;
    while (exp3_q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("drain3 queue empty", 32'(exp3_q.size()), 32'd0);
    repeat (8) @(negedge clk);
    check("final idle3", 32'(busy3), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
